// File: rtl/arm_spi_lb_slave.sv
// arm_spi_lb_slave: oversampled SPI slave turning each ARM SPI frame into one localbus read or write.
// Define SPI_LB_PARITY_EN for a 41-bit frame carrying an even-parity bit (checked on writes, driven on reads).
module arm_spi_lb_slave #(
  parameter int RD_LAT = 4,
  parameter int WR_LEN = 2
) (
  input  logic        I_sys_clk,
  input  logic        I_rst_n,
  input  logic        I_arm_spi_cs,
  input  logic        I_arm_spi_clk,
  input  logic        I_arm_spi_sdi,
  output logic        O_arm_spi_sdo,
  output logic        O_arm_spi_sdo_en,
  output logic        O_sub_cs_n,
  output logic        O_sub_rd_n,
  output logic        O_sub_wr_n,
  output logic [15:0] O_sub_addr,
  output logic [15:0] O_sub_din,
  input  logic [15:0] I_sub_dout,
  output logic        O_frame_err
);

  localparam logic [5:0] RD_CNT_INIT = 6'(RD_LAT - 1);
  localparam logic [5:0] WR_CNT_INIT = 6'(WR_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_TURN, S_DATA, S_PAR, S_DONE} shift_state_t;
  typedef enum logic [1:0] {B_IDLE, B_RD, B_WR} bus_state_t;

`ifdef SPI_LB_PARITY_EN
  function automatic logic even_par16(input logic [15:0] d);
    return ^d;
  endfunction
`endif

  logic         cs_s1_r, cs_s2_r;
  logic         sclk_s1_r, sclk_s2_r, sclk_s3_r;
  logic         sdi_s1_r, sdi_s2_r, sdi_r;
  logic         rise_r, fall_r;
  logic [1:0]   sync_ok_r;
  logic         armed_r;
  shift_state_t shift_state_r, shift_nxt_s;
  logic [5:0]   bit_cnt_r;
  logic [15:0]  hdr_r, dat_r;
  logic         rd_start_s, wr_start_s, par_err_s, trunc_s, rd_done_s;
  logic [15:0]  rd_addr_s, wr_addr_s, wr_data_s;
  bus_state_t   bus_state_r, bus_nxt_s;
  logic [5:0]   bus_cnt_r, bus_cnt_nxt_s;
  logic         sub_cs_n_r, sub_rd_n_r, sub_wr_n_r;
  logic         cs_n_nxt_s, rd_n_nxt_s, wr_n_nxt_s;
  logic [15:0]  sub_addr_r, sub_din_r, addr_nxt_s, din_nxt_s;
  logic [15:0]  tx_r;
  logic         sdo_r, sdo_en_r, rd_keep_r, frame_err_r;
`ifdef SPI_LB_PARITY_EN
  logic         tx_par_r;
  logic         par_ok_s;
`endif

  // Pin synchronisers, registered sclk edge strobes, and arming once cs is seen high after reset
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cs_s1_r   <= 1'b1;
      cs_s2_r   <= 1'b1;
      sclk_s1_r <= 1'b0;
      sclk_s2_r <= 1'b0;
      sclk_s3_r <= 1'b0;
      sdi_s1_r  <= 1'b0;
      sdi_s2_r  <= 1'b0;
      sdi_r     <= 1'b0;
      rise_r    <= 1'b0;
      fall_r    <= 1'b0;
      sync_ok_r <= 2'b00;
      armed_r   <= 1'b0;
    end else begin
      cs_s1_r   <= I_arm_spi_cs;
      cs_s2_r   <= cs_s1_r;
      sclk_s1_r <= I_arm_spi_clk;
      sclk_s2_r <= sclk_s1_r;
      sclk_s3_r <= sclk_s2_r;
      sdi_s1_r  <= I_arm_spi_sdi;
      sdi_s2_r  <= sdi_s1_r;
      sdi_r     <= sdi_s2_r;
      rise_r    <= sclk_s2_r & ~sclk_s3_r & ~cs_s2_r;
      fall_r    <= ~sclk_s2_r & sclk_s3_r & ~cs_s2_r;
      sync_ok_r <= {sync_ok_r[0], 1'b1};
      armed_r   <= armed_r | (sync_ok_r[1] & cs_s2_r);
    end
  end

  // Shift FSM state register
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      shift_state_r <= S_IDLE;
    end else begin
      shift_state_r <= shift_nxt_s;
    end
  end

  // Shift FSM next state: frame phases advance on the last rising edge of each field
  always_comb begin
    shift_nxt_s = shift_state_r;
    if (cs_s2_r) begin
      shift_nxt_s = S_IDLE;
    end else begin
      case (shift_state_r)
        S_IDLE: begin
          if (armed_r) shift_nxt_s = S_HDR;
          else         shift_nxt_s = S_IDLE;
        end
        S_HDR: begin
          if (rise_r && (bit_cnt_r == 6'd15)) shift_nxt_s = S_TURN;
          else                                shift_nxt_s = S_HDR;
        end
        S_TURN: begin
          if (rise_r && (bit_cnt_r == 6'd23)) shift_nxt_s = S_DATA;
          else                                shift_nxt_s = S_TURN;
        end
        S_DATA: begin
`ifdef SPI_LB_PARITY_EN
          if (rise_r && (bit_cnt_r == 6'd39)) shift_nxt_s = S_PAR;
`else
          if (rise_r && (bit_cnt_r == 6'd39)) shift_nxt_s = S_DONE;
`endif
          else                                shift_nxt_s = S_DATA;
        end
`ifdef SPI_LB_PARITY_EN
        S_PAR: begin
          if (rise_r) shift_nxt_s = S_DONE;
          else        shift_nxt_s = S_PAR;
        end
`endif
        S_DONE:  shift_nxt_s = S_DONE;
        default: shift_nxt_s = S_IDLE;
      endcase
    end
  end

  // Bit counter (saturating) and header/data shift registers, cleared between frames
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      bit_cnt_r <= 6'd0;
      hdr_r     <= 16'h0000;
      dat_r     <= 16'h0000;
    end else if (cs_s2_r || (shift_state_r == S_IDLE)) begin
      bit_cnt_r <= 6'd0;
      hdr_r     <= 16'h0000;
      dat_r     <= 16'h0000;
    end else begin
      if (rise_r && (bit_cnt_r != 6'd63)) bit_cnt_r <= bit_cnt_r + 6'd1;
      if (rise_r && (shift_state_r == S_HDR)) hdr_r <= {hdr_r[14:0], sdi_r};
      if (rise_r && (shift_state_r == S_DATA)) dat_r <= {dat_r[14:0], sdi_r};
    end
  end

  // Bus requests derived from the frame; sdi_r is the bit arriving with the current rising edge
  always_comb begin
    rd_start_s = rise_r && (shift_state_r == S_HDR) && (bit_cnt_r == 6'd15) && hdr_r[14];
    rd_addr_s  = {1'b0, hdr_r[13:0], sdi_r};
    wr_addr_s  = {1'b0, hdr_r[14:0]};
`ifdef SPI_LB_PARITY_EN
    par_ok_s   = ~(even_par16(hdr_r) ^ even_par16(dat_r) ^ sdi_r);
    wr_data_s  = dat_r;
    wr_start_s = rise_r && (shift_state_r == S_PAR) && !hdr_r[15] && par_ok_s;
    par_err_s  = rise_r && (shift_state_r == S_PAR) && !hdr_r[15] && !par_ok_s;
`else
    wr_data_s  = {dat_r[14:0], sdi_r};
    wr_start_s = rise_r && (shift_state_r == S_DATA) && (bit_cnt_r == 6'd39) && !hdr_r[15];
    par_err_s  = 1'b0;
`endif
    trunc_s    = cs_s2_r && (bit_cnt_r != 6'd0) &&
                 ((shift_state_r == S_HDR) || (shift_state_r == S_TURN) ||
                  (shift_state_r == S_DATA) || (shift_state_r == S_PAR));
    rd_done_s  = (bus_state_r == B_RD) && (bus_cnt_r == 6'd0);
  end

  // Bus FSM state and registered localbus outputs
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      bus_state_r <= B_IDLE;
      bus_cnt_r   <= 6'd0;
      sub_cs_n_r  <= 1'b1;
      sub_rd_n_r  <= 1'b1;
      sub_wr_n_r  <= 1'b1;
      sub_addr_r  <= 16'h0000;
      sub_din_r   <= 16'h0000;
    end else begin
      bus_state_r <= bus_nxt_s;
      bus_cnt_r   <= bus_cnt_nxt_s;
      sub_cs_n_r  <= cs_n_nxt_s;
      sub_rd_n_r  <= rd_n_nxt_s;
      sub_wr_n_r  <= wr_n_nxt_s;
      sub_addr_r  <= addr_nxt_s;
      sub_din_r   <= din_nxt_s;
    end
  end

  // Bus FSM next state: cs_n and the active strobe fall and rise together
  always_comb begin
    bus_nxt_s     = bus_state_r;
    bus_cnt_nxt_s = bus_cnt_r;
    cs_n_nxt_s    = sub_cs_n_r;
    rd_n_nxt_s    = sub_rd_n_r;
    wr_n_nxt_s    = sub_wr_n_r;
    addr_nxt_s    = sub_addr_r;
    din_nxt_s     = sub_din_r;
    case (bus_state_r)
      B_IDLE: begin
        if (rd_start_s) begin
          bus_nxt_s     = B_RD;
          bus_cnt_nxt_s = RD_CNT_INIT;
          cs_n_nxt_s    = 1'b0;
          rd_n_nxt_s    = 1'b0;
          addr_nxt_s    = rd_addr_s;
        end else if (wr_start_s) begin
          bus_nxt_s     = B_WR;
          bus_cnt_nxt_s = WR_CNT_INIT;
          cs_n_nxt_s    = 1'b0;
          wr_n_nxt_s    = 1'b0;
          addr_nxt_s    = wr_addr_s;
          din_nxt_s     = wr_data_s;
        end else begin
          bus_nxt_s     = B_IDLE;
        end
      end
      B_RD: begin
        if (bus_cnt_r == 6'd0) begin
          bus_nxt_s  = B_IDLE;
          cs_n_nxt_s = 1'b1;
          rd_n_nxt_s = 1'b1;
        end else begin
          bus_cnt_nxt_s = bus_cnt_r - 6'd1;
        end
      end
      B_WR: begin
        if (bus_cnt_r == 6'd0) begin
          bus_nxt_s  = B_IDLE;
          cs_n_nxt_s = 1'b1;
          wr_n_nxt_s = 1'b1;
        end else begin
          bus_cnt_nxt_s = bus_cnt_r - 6'd1;
        end
      end
      default: begin
        bus_nxt_s  = B_IDLE;
        cs_n_nxt_s = 1'b1;
        rd_n_nxt_s = 1'b1;
        wr_n_nxt_s = 1'b1;
      end
    endcase
  end

  // Read data path: capture on the last strobe cycle unless the frame was abandoned, shift on sclk falls
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      tx_r      <= 16'h0000;
      sdo_r     <= 1'b0;
      sdo_en_r  <= 1'b0;
      rd_keep_r <= 1'b0;
`ifdef SPI_LB_PARITY_EN
      tx_par_r  <= 1'b0;
`endif
    end else begin
      sdo_en_r <= ~cs_s2_r;
      if (cs_s2_r) rd_keep_r <= 1'b0;
      else if (rd_start_s && (bus_state_r == B_IDLE)) rd_keep_r <= 1'b1;
      else if (rd_done_s) rd_keep_r <= 1'b0;

      if (rd_done_s && rd_keep_r && !cs_s2_r) begin
        tx_r <= I_sub_dout;
`ifdef SPI_LB_PARITY_EN
        tx_par_r <= even_par16(I_sub_dout);
`endif
      end else if (fall_r && (shift_state_r == S_DATA) && hdr_r[15]) begin
        tx_r <= {tx_r[14:0], 1'b0};
      end

      if (cs_s2_r) begin
        sdo_r <= 1'b0;
      end else if (fall_r) begin
        if ((shift_state_r == S_DATA) && hdr_r[15]) sdo_r <= tx_r[15];
`ifdef SPI_LB_PARITY_EN
        else if ((shift_state_r == S_PAR) && hdr_r[15]) sdo_r <= tx_par_r;
`endif
        else sdo_r <= 1'b0;
      end
    end
  end

  // Frame error pulse: truncation when cs rises mid-frame, or a bad write parity bit
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= trunc_s | par_err_s;
    end
  end

  assign O_arm_spi_sdo    = sdo_r;
  assign O_arm_spi_sdo_en = sdo_en_r;
  assign O_sub_cs_n       = sub_cs_n_r;
  assign O_sub_rd_n       = sub_rd_n_r;
  assign O_sub_wr_n       = sub_wr_n_r;
  assign O_sub_addr       = sub_addr_r;
  assign O_sub_din        = sub_din_r;
  assign O_frame_err      = frame_err_r;

endmodule
